// File: rtl/clk_period_meter.sv
// Purpose : measures period and high time of an asynchronous slow signal in IN_CLK cycles,
//           with lock detection, sticky loss-of-signal and a wrapping rising-edge counter.
// Latency : SIG_IN rise at first sync flop -> VALID strobe SYNC_STAGES+1 IN_CLK cycles later.
// Backpr. : none; results are strobed on VALID and held until the next measurement.
// Ports   : IN_CLK/RST (sync, active high), SIG_IN (async input),
//           PERIOD/HIGH_TIME/VALID/LOCKED/TIMEOUT/EDGE_CNT (all registered).
module clk_period_meter #(
   parameter int CNT_WIDTH      = 32,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 100000000,
   parameter int EDGE_WIDTH     = 16
) (
   input  logic                  IN_CLK,
   input  logic                  RST,
   input  logic                  SIG_IN,
   output logic [CNT_WIDTH-1:0]  PERIOD,
   output logic [CNT_WIDTH-1:0]  HIGH_TIME,
   output logic                  VALID,
   output logic                  LOCKED,
   output logic                  TIMEOUT,
   output logic [EDGE_WIDTH-1:0] EDGE_CNT
);

   typedef enum logic {IDLE, MEASURE} state_t;

   localparam logic [CNT_WIDTH-1:0] TMO = CNT_WIDTH'(TIMEOUT_CYCLES);

   state_t                  state_q;
   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    prev_q;
   logic [CNT_WIDTH-1:0]    cnt_q;
   logic [CNT_WIDTH-1:0]    cnt_d;
   logic [CNT_WIDTH-1:0]    cnt_inc;
   logic [CNT_WIDTH-1:0]    hi_cap_q;
   logic                    fall_seen_q;
   logic                    have_vld_q;
   logic [CNT_WIDTH-1:0]    period_q;
   logic [CNT_WIDTH-1:0]    high_q;
   logic                    vld_q;
   logic                    locked_q;
   logic                    timeout_q;
   logic [EDGE_WIDTH-1:0]   edge_q;

   logic s;
   logic rise;
   logic fall;
   logic tmo_hit;

   always_comb begin
      s       = sync_q[SYNC_STAGES-1];
      rise    = s & ~prev_q;
      fall    = ~s & prev_q;
      // Saturating increment: a stuck counter must never wrap back into range.
      cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
      cnt_d   = rise ? '0 : cnt_inc;
      tmo_hit = (cnt_inc == TMO);
   end

   always_ff @(posedge IN_CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         sync_q      <= '0;
         prev_q      <= 1'b0;
         cnt_q       <= '0;
         hi_cap_q    <= '0;
         fall_seen_q <= 1'b0;
         have_vld_q  <= 1'b0;
         period_q    <= '0;
         high_q      <= '0;
         vld_q       <= 1'b0;
         locked_q    <= 1'b0;
         timeout_q   <= 1'b0;
         edge_q      <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], SIG_IN};
         prev_q <= s;
         cnt_q  <= cnt_d;
         vld_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               // First rise only opens a measurement window; nothing to report yet.
               if (rise) begin
                  edge_q      <= edge_q + EDGE_WIDTH'(1);
                  fall_seen_q <= 1'b0;
                  have_vld_q  <= 1'b0;
                  state_q     <= MEASURE;
               end
            end
            MEASURE: begin
               // Rise takes priority over a coincident timeout.
               if (rise) begin
                  period_q    <= cnt_inc;
                  high_q      <= fall_seen_q ? hi_cap_q : '0;
                  vld_q       <= 1'b1;
                  edge_q      <= edge_q + EDGE_WIDTH'(1);
                  timeout_q   <= 1'b0;
                  locked_q    <= have_vld_q && (cnt_inc == period_q);
                  have_vld_q  <= 1'b1;
                  fall_seen_q <= 1'b0;
               end else if (tmo_hit) begin
                  timeout_q   <= 1'b1;
                  locked_q    <= 1'b0;
                  have_vld_q  <= 1'b0;
                  state_q     <= IDLE;
               end else if (fall && !fall_seen_q) begin
                  // Only the first fall after a rise defines the high time.
                  hi_cap_q    <= cnt_inc;
                  fall_seen_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign PERIOD    = period_q;
   assign HIGH_TIME = high_q;
   assign VALID     = vld_q;
   assign LOCKED    = locked_q;
   assign TIMEOUT   = timeout_q;
   assign EDGE_CNT  = edge_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Purpose : directed, table-driven bench for clk_period_meter (TIMEOUT_CYCLES=64, EDGE_WIDTH=4).
// Latency : expects VALID SYNC_STAGES+1 cycles after a driven rise.
// Backpr. : not applicable.
module tb_clk_period_meter;

   localparam int CW  = 16;
   localparam int SS  = 2;
   localparam int TMO = 64;
   localparam int EW  = 4;

   logic          IN_CLK = 1'b0;
   logic          RST    = 1'b1;
   logic          SIG_IN = 1'b0;
   logic [CW-1:0] PERIOD;
   logic [CW-1:0] HIGH_TIME;
   logic          VALID;
   logic          LOCKED;
   logic          TIMEOUT;
   logic [EW-1:0] EDGE_CNT;

   clk_period_meter #(
      .CNT_WIDTH(CW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TMO), .EDGE_WIDTH(EW)
   ) dut (
      .IN_CLK(IN_CLK), .RST(RST), .SIG_IN(SIG_IN),
      .PERIOD(PERIOD), .HIGH_TIME(HIGH_TIME), .VALID(VALID),
      .LOCKED(LOCKED), .TIMEOUT(TIMEOUT), .EDGE_CNT(EDGE_CNT)
   );

   always #5 IN_CLK = ~IN_CLK;

   int cyc = 0;
   always @(posedge IN_CLK) cyc <= cyc + 1;

   typedef struct {
      int c;
      int per;
      int hi;
      bit lck;
   } vrec_t;
   vrec_t vq[$];

   always @(negedge IN_CLK)
      if (VALID) vq.push_back('{cyc, int'(PERIOD), int'(HIGH_TIME), LOCKED});

   // One row = one signal period (high h, low l) starting with a rise,
   // plus the VALID expected from that rise and the status at period end.
   typedef struct {
      int h;
      int l;
      bit vld;
      int per;
      int hi;
      bit lck;
      int edg;
      bit tmo;
   } row_t;
   row_t rows[21];

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drv(input bit v, input int n);
      repeat (n) begin
         SIG_IN = v;
         @(posedge IN_CLK);
         #1;
      end
   endtask

   task automatic do_reset(input string nm);
      SIG_IN = 1'b0;
      RST    = 1'b1;
      @(posedge IN_CLK);
      #1;
      RST = 1'b0;
      chk({nm, " PERIOD"},    int'(PERIOD), 0);
      chk({nm, " HIGH_TIME"}, int'(HIGH_TIME), 0);
      chk({nm, " VALID"},     int'(VALID), 0);
      chk({nm, " LOCKED"},    int'(LOCKED), 0);
      chk({nm, " TIMEOUT"},   int'(TIMEOUT), 0);
      chk({nm, " EDGE_CNT"},  int'(EDGE_CNT), 0);
   endtask

   task automatic run_rows(input int lo, input int hi);
      int    n0;
      int    d;
      vrec_t r;
      for (int i = lo; i <= hi; i++) begin
         n0 = vq.size();
         d  = cyc;
         drv(1'b1, rows[i].h);
         drv(1'b0, rows[i].l);
         chk($sformatf("row%0d valid count", i), vq.size() - n0, int'(rows[i].vld));
         if (rows[i].vld && vq.size() > n0) begin
            r = vq[vq.size()-1];
            chk($sformatf("row%0d PERIOD", i),    r.per, rows[i].per);
            chk($sformatf("row%0d HIGH_TIME", i), r.hi, rows[i].hi);
            chk($sformatf("row%0d LOCKED", i),    int'(r.lck), int'(rows[i].lck));
            chk($sformatf("row%0d latency", i),   r.c - d, SS + 1);
         end
         chk($sformatf("row%0d EDGE_CNT", i), int'(EDGE_CNT), rows[i].edg);
         chk($sformatf("row%0d TIMEOUT", i),  int'(TIMEOUT), int'(rows[i].tmo));
      end
   endtask

   // Waits (bounded) for TIMEOUT; returns the cycle it was first seen or -1.
   task automatic wait_tmo(output int at);
      at = -1;
      for (int k = 0; k < 200 && at < 0; k++) begin
         @(posedge IN_CLK);
         #1;
         if (TIMEOUT) at = cyc;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int    n0;
      int    d;
      int    at;
      vrec_t r;

      //          h   l  vld per hi lck edg tmo
      rows[0]  = '{8,  7, 0,  0,  0, 0,  1, 0};
      rows[1]  = '{8,  7, 1, 15,  8, 0,  2, 0};
      rows[2]  = '{8,  7, 1, 15,  8, 1,  3, 0};
      rows[3]  = '{8,  7, 1, 15,  8, 1,  4, 0};
      rows[4]  = '{8,  7, 1, 15,  8, 1,  5, 0};
      rows[5]  = '{8,  7, 1, 15,  8, 1,  6, 0};
      rows[6]  = '{5,  5, 1, 15,  8, 1,  7, 0};
      rows[7]  = '{5,  5, 1, 10,  5, 0,  8, 0};
      rows[8]  = '{5,  5, 1, 10,  5, 1,  9, 0};
      rows[9]  = '{8,  7, 1, 10,  5, 1, 10, 0};
      rows[10] = '{8,  7, 1, 15,  8, 0, 11, 0};
      rows[11] = '{8,  7, 1, 15,  8, 1, 12, 0};
      // restart after loss of signal
      rows[12] = '{8,  7, 0,  0,  0, 0, 13, 1};
      rows[13] = '{8,  7, 1, 15,  8, 0, 14, 0};
      // after mid-period reset; period 64 makes rise coincide with timeout
      rows[14] = '{8,  7, 0,  0,  0, 0,  1, 0};
      rows[15] = '{8,  7, 1, 15,  8, 0,  2, 0};
      rows[16] = '{32, 32, 1, 15, 8, 1,  3, 0};
      rows[17] = '{32, 32, 1, 64, 32, 0, 4, 0};
      rows[18] = '{32, 32, 1, 64, 32, 1, 5, 0};
      // after constant-high timeout
      rows[19] = '{8,  7, 0,  0,  0, 0,  2, 1};
      rows[20] = '{8,  7, 1, 15,  8, 0,  3, 0};

      repeat (2) @(posedge IN_CLK);
      #1;
      do_reset("reset");
      drv(1'b0, 3);

      run_rows(0, 11);

      // Stop toggling: TIMEOUT exactly TMO cycles after the last VALID strobe.
      r = vq[vq.size()-1];
      SIG_IN = 1'b0;
      wait_tmo(at);
      chk("stop timeout delay", (at < 0) ? -1 : at - r.c, TMO);
      chk("stop LOCKED",    int'(LOCKED), 0);
      chk("stop PERIOD",    int'(PERIOD), 15);
      chk("stop HIGH_TIME", int'(HIGH_TIME), 8);
      drv(1'b0, 5);

      run_rows(12, 13);

      // Reset in the middle of a high phase.
      drv(1'b1, 4);
      do_reset("midreset");
      drv(1'b0, 3);
      run_rows(14, 18);

      // Constant high after one rise: no VALID, timeout TMO cycles after the rise.
      do_reset("hold reset");
      drv(1'b0, 5);
      n0 = vq.size();
      d  = cyc;
      SIG_IN = 1'b1;
      wait_tmo(at);
      chk("hold timeout delay", (at < 0) ? -1 : at - d, SS + 1 + TMO);
      chk("hold valid count", vq.size() - n0, 0);
      chk("hold EDGE_CNT", int'(EDGE_CNT), 1);
      drv(1'b1, 3);
      drv(1'b0, 7);
      run_rows(19, 20);

      // Period-2 toggle; first VALID closes the preceding 15-cycle period.
      n0 = vq.size();
      repeat (10) begin
         drv(1'b1, 1);
         drv(1'b0, 1);
      end
      drv(1'b0, 4);
      chk("p2 valid count", vq.size() - n0, 10);
      if (vq.size() - n0 >= 10) begin
         chk("p2 first PERIOD", vq[n0].per, 15);
         for (int k = 1; k < 10; k++) begin
            chk($sformatf("p2 v%0d PERIOD", k),    vq[n0+k].per, 2);
            chk($sformatf("p2 v%0d HIGH_TIME", k), vq[n0+k].hi, 1);
            chk($sformatf("p2 v%0d spacing", k),   vq[n0+k].c - vq[n0+k-1].c, 2);
            if (k >= 2)
               chk($sformatf("p2 v%0d LOCKED", k), int'(vq[n0+k].lck), 1);
         end
      end

      // Edge counter wrap: 17 rises on a 4-bit counter.
      do_reset("wrap reset");
      drv(1'b0, 3);
      repeat (17) begin
         drv(1'b1, 2);
         drv(1'b0, 2);
      end
      drv(1'b0, 4);
      chk("wrap EDGE_CNT", int'(EDGE_CNT), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
